// File: rtl/b10_arb_pkg.sv
// Shared types and widths for the vote-transfer arbiter.
package b10_arb_pkg;

  localparam int VOTE_W = 4;
  localparam int CNT_W  = 8;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SEND     = 2'd1,
    WAIT_LOW = 2'd2,
    ACK      = 2'd3
  } arb_state_e;

  // Index of the set bit in a one-hot vector of up to 8 stations.
  function automatic logic [2:0] oh2idx(input logic [7:0] oh);
    logic [2:0] r;
    r = '0;
    for (int i = 0; i < 8; i++)
      if (oh[i]) r = 3'(i);
    return r;
  endfunction

endpackage

// File: rtl/b10_vote_arbiter_if.sv
// Station/receiver bundle of the vote arbiter; master drives requests, slave is the arbiter.
interface b10_vote_arbiter_if #(parameter int NREQ = 4);
  import b10_arb_pkg::*;

  logic [NREQ-1:0]              req;
  logic [NREQ-1:0][VOTE_W-1:0]  vote_in;
  logic                         cts;
  logic [NREQ-1:0]              gnt;
  logic [NREQ-1:0]              ack;
  logic                         rts;
  logic [VOTE_W-1:0]            v_out;
  logic                         err;
  logic [CNT_W-1:0]             xfer_cnt;

  modport master (
    output req, vote_in, cts,
    input  gnt, ack, rts, v_out, err, xfer_cnt
  );

  modport slave (
    input  req, vote_in, cts,
    output gnt, ack, rts, v_out, err, xfer_cnt
  );
endinterface

// File: rtl/b10_rr_pick.sv
// Combinational round-robin picker: first requester strictly after ptr, wrapping.
module b10_rr_pick #(
  parameter int NREQ = 4,
  parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] win,
  output logic            vld
);

  logic [PW:0] sum;

  always_comb begin
    win = '0;
    vld = 1'b0;
    sum = '0;
    for (int k = 1; k <= NREQ; k++) begin
      sum = {1'b0, ptr} + (PW+1)'(k);
      if (sum >= (PW+1)'(NREQ)) sum = sum - (PW+1)'(NREQ);
      if (!vld && req[sum[PW-1:0]]) begin
        win[sum[PW-1:0]] = 1'b1;
        vld              = 1'b1;
      end
    end
  end

endmodule

// File: rtl/b10_vote_arbiter.sv
// Round-robin arbiter moving one station's vote over a 4-phase rts/cts channel.
// Optional handshake watchdog enabled by defining B10_ARB_TIMEOUT_EN.
module b10_vote_arbiter
  import b10_arb_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 15
) (
  input  logic               clock,
  input  logic               reset,
  b10_vote_arbiter_if.slave  bus
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  arb_state_e         state;
  logic [NREQ-1:0]    gnt_q, ack_q, pick_oh;
  logic               pick_vld;
  logic [PW-1:0]      ptr, pick_idx, gnt_idx;
  logic               rts_q;
  logic [VOTE_W-1:0]  v_q;
  logic [CNT_W-1:0]   xfer_q;
  logic               to_hit;

  b10_rr_pick #(.NREQ(NREQ), .PW(PW)) u_pick (
    .req (bus.req),
    .ptr (ptr),
    .win (pick_oh),
    .vld (pick_vld)
  );

  assign pick_idx = PW'(oh2idx(8'(pick_oh)));
  assign gnt_idx  = PW'(oh2idx(8'(gnt_q)));

`ifdef B10_ARB_TIMEOUT_EN
  logic [7:0] wd_cnt;
  logic       err_q;

  // Counter sits at zero in IDLE, so it is already clear on SEND entry.
  assign to_hit = (state == SEND || state == WAIT_LOW) && (wd_cnt == 8'(TIMEOUT));

  always_ff @(posedge clock) begin
    if (reset) begin
      wd_cnt <= '0;
      err_q  <= 1'b0;
    end else begin
      err_q <= to_hit;
      if (state == SEND || state == WAIT_LOW) wd_cnt <= wd_cnt + 8'd1;
      else                                    wd_cnt <= '0;
    end
  end

  assign bus.err = err_q;
`else
  assign to_hit  = 1'b0;
  assign bus.err = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= IDLE;
      gnt_q  <= '0;
      ack_q  <= '0;
      rts_q  <= 1'b0;
      v_q    <= '0;
      xfer_q <= '0;
      ptr    <= PW'(NREQ - 1);
    end else begin
      ack_q <= '0;
      case (state)
        IDLE: begin
          if (pick_vld) begin
            state <= SEND;
            gnt_q <= pick_oh;
            v_q   <= bus.vote_in[pick_idx];
            rts_q <= 1'b1;
          end
        end
        SEND: begin
          if (to_hit) begin
            state <= IDLE;
            rts_q <= 1'b0;
            gnt_q <= '0;
            ptr   <= gnt_idx;
          end else if (bus.cts) begin
            state <= WAIT_LOW;
            rts_q <= 1'b0;
          end
        end
        WAIT_LOW: begin
          if (to_hit) begin
            state <= IDLE;
            gnt_q <= '0;
            ptr   <= gnt_idx;
          end else if (!bus.cts) begin
            state  <= ACK;
            ack_q  <= gnt_q;
            xfer_q <= xfer_q + 8'd1;
            ptr    <= gnt_idx;
          end
        end
        ACK: begin
          state <= IDLE;
          gnt_q <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.gnt      = gnt_q;
  assign bus.ack      = ack_q;
  assign bus.rts      = rts_q;
  assign bus.v_out    = v_q;
  assign bus.xfer_cnt = xfer_q;

endmodule

// File: tb/tb_b10_vote_arbiter.sv
// Randomized bench for b10_vote_arbiter against a transaction-level round-robin model.
module tb_b10_vote_arbiter;
  import b10_arb_pkg::*;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  b10_vote_arbiter_if #(.NREQ(4)) bus ();

  b10_vote_arbiter #(.NREQ(4), .TIMEOUT(15)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int         n_chk = 0;
  int         n_err = 0;
  int         m_ptr;
  logic [7:0] m_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // Reference winner: first requester after the last served station, wrapping.
  function automatic int rr_expect(input logic [3:0] r, input int p);
    for (int k = 1; k <= 4; k++) begin
      int j;
      j = (p + k) % 4;
      if (r[2'(j)]) return j;
    end
    return -1;
  endfunction

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  // One full transfer: d_send cycles of extra SEND, d_wait extra cycles of cts high.
  task automatic do_xfer(input logic [3:0] r, input logic [15:0] vote,
                         input int d_send, input int d_wait, input bit noisy);
    int              w;
    logic [3:0][3:0] vs;
    logic [3:0]      oh;
    vs          = vote;
    bus.req     = r;
    bus.vote_in = vs;
    w  = rr_expect(r, m_ptr);
    oh = 4'(1 << w);
    cyc();
    chk("gnt",      32'(bus.gnt),   32'(oh));
    chk("rts_rise", 32'(bus.rts),   32'd1);
    chk("v_latch",  32'(bus.v_out), 32'(vs[2'(w)]));
    if (noisy) begin
      bus.req     = 4'($urandom);
      bus.vote_in = 16'($urandom);
    end
    repeat (d_send) begin
      cyc();
      chk("rts_hold", 32'(bus.rts), 32'd1);
    end
    bus.cts = 1'b1;
    cyc();
    chk("rts_fall", 32'(bus.rts), 32'd0);
    repeat (d_wait) begin
      cyc();
      chk("no_ack", 32'(bus.ack), 32'd0);
    end
    bus.cts = 1'b0;
    cyc();
    m_cnt = m_cnt + 8'd1;
    chk("ack",      32'(bus.ack),      32'(oh));
    chk("xfer_cnt", 32'(bus.xfer_cnt), 32'(m_cnt));
    chk("v_hold",   32'(bus.v_out),    32'(vs[2'(w)]));
    chk("err_idle", 32'(bus.err),      32'd0);
    m_ptr = w;
    cyc();
    chk("ack_clr", 32'(bus.ack),   32'd0);
    chk("gnt_clr", 32'(bus.gnt),   32'd0);
    chk("v_keep",  32'(bus.v_out), 32'(vs[2'(w)]));
    bus.req = '0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog sim_time obs=expired exp=finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    bus.req     = '0;
    bus.vote_in = '0;
    bus.cts     = 1'b0;
    reset       = 1'b1;
    m_ptr       = 3;
    m_cnt       = '0;
    cyc();
    cyc();
    chk("rst_gnt",  32'(bus.gnt),      32'd0);
    chk("rst_ack",  32'(bus.ack),      32'd0);
    chk("rst_rts",  32'(bus.rts),      32'd0);
    chk("rst_vout", 32'(bus.v_out),    32'd0);
    chk("rst_cnt",  32'(bus.xfer_cnt), 32'd0);
    chk("rst_err",  32'(bus.err),      32'd0);
    reset = 1'b0;

    // All stations requesting, cts echoing rts: strict rotation, 4-cycle transfers.
    repeat (5) do_xfer(4'hF, 16'($urandom), 0, 0, 1'b0);

    // Single requester, fixed vote, cts high for three cycles.
    do_xfer(4'b0100, 16'h0A00, 0, 2, 1'b0);

    // Reset while WAIT_LOW with the ack still pending.
    bus.req = 4'b1000;
    cyc();
    bus.cts = 1'b1;
    cyc();
    reset = 1'b1;
    cyc();
    chk("rstw_rts", 32'(bus.rts), 32'd0);
    chk("rstw_gnt", 32'(bus.gnt), 32'd0);
    chk("rstw_ack", 32'(bus.ack), 32'd0);
    chk("rstw_err", 32'(bus.err), 32'd0);
    chk("rstw_cnt", 32'(bus.xfer_cnt), 32'd0);
    reset   = 1'b0;
    bus.cts = 1'b0;
    m_ptr   = 3;
    m_cnt   = '0;
    do_xfer(4'hF, 16'($urandom), 0, 0, 1'b0);

    // Reset during SEND.
    bus.req = 4'b0010;
    cyc();
    chk("send_rts", 32'(bus.rts), 32'd1);
    reset = 1'b1;
    cyc();
    chk("rsts_rts", 32'(bus.rts), 32'd0);
    chk("rsts_ack", 32'(bus.ack), 32'd0);
    reset = 1'b0;
    m_ptr = 3;
    m_cnt = '0;

`ifdef B10_ARB_TIMEOUT_EN
    begin
      bus.req = 4'b0100;
      bus.cts = 1'b0;
      cyc();
      chk("to_gnt", 32'(bus.gnt), 32'b0100);
      bus.req = '0;
      repeat (15) begin
        cyc();
        chk("to_wait_err", 32'(bus.err), 32'd0);
        chk("to_wait_rts", 32'(bus.rts), 32'd1);
      end
      cyc();
      chk("to_err", 32'(bus.err),      32'd1);
      chk("to_rts", 32'(bus.rts),      32'd0);
      chk("to_gnt0", 32'(bus.gnt),     32'd0);
      chk("to_ack", 32'(bus.ack),      32'd0);
      chk("to_cnt", 32'(bus.xfer_cnt), 32'(m_cnt));
      m_ptr = 2;
      cyc();
      chk("to_err_clr", 32'(bus.err), 32'd0);
    end
`endif

    // Random traffic long enough to wrap xfer_cnt through 255 -> 0.
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        bus.req = '0;
        repeat ($urandom_range(1, 3)) begin
          cyc();
          chk("idle_gnt", 32'(bus.gnt), 32'd0);
          chk("idle_rts", 32'(bus.rts), 32'd0);
        end
      end
      do_xfer(4'($urandom_range(1, 15)), 16'($urandom),
              $urandom_range(0, 3), $urandom_range(0, 3), 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/b10_vote_arbiter.md
B10_VOTE_ARBITER -- requirements
Module: b10_vote_arbiter

Interface
REQ-001 Parameter NREQ, default 4: number of voting stations sharing the vote-transfer channel (2..8).
REQ-002 Parameter TIMEOUT, default 15: handshake watchdog limit in cycles (1..255).
REQ-003 clock  in  1  sole clock; all state updates on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 req  in  NREQ  per-station transfer request, level, held until ack.
REQ-006 vote_in  in  4*NREQ  per-station 4-bit vote; nibble i belongs to station i.
REQ-007 cts  in  1  downstream clear-to-send, 4-phase handshake response.
REQ-008 gnt  out  NREQ  one-hot grant, registered.
REQ-009 ack  out  NREQ  one-cycle completion pulse to the granted station.
REQ-010 rts  out  1  request-to-send to the downstream vote receiver.
REQ-011 v_out  out  4  latched vote of the granted station.
REQ-012 err  out  1  one-cycle watchdog abort pulse.
REQ-013 xfer_cnt  out  8  count of completed transfers.

Function
REQ-014 The FSM SHALL have states IDLE, SEND, WAIT_LOW and ACK.
REQ-015 IDLE: if any req bit is sampled high, the block SHALL pick a winner round-robin, searching from ptr+1 mod NREQ upward; on the same edge it SHALL latch that station's nibble into v_out, set the winner's gnt bit and enter SEND.
REQ-016 rts SHALL be high exactly while in SEND, so rts rises one cycle after req is sampled.
REQ-017 SEND: on cts sampled high, the block SHALL enter WAIT_LOW with rts low.
REQ-018 WAIT_LOW: on cts sampled low, the block SHALL enter ACK.
REQ-019 ACK: ack[winner] SHALL be high for this single cycle; xfer_cnt SHALL increment, wrapping 255->0; ptr SHALL be set to the winner; gnt SHALL clear; the next state SHALL be IDLE.
REQ-020 v_out SHALL be held stable from SEND entry through ACK and retain its value in IDLE.
REQ-021 A winner that drops req before ACK SHALL NOT abort the transfer; the transfer completes normally.
REQ-022 req changes outside IDLE SHALL be ignored until the next return to IDLE.
REQ-023 A station that stays requesting after its ack SHALL NOT win again while any other station is requesting.
REQ-024 cts high already on SEND entry SHALL advance to WAIT_LOW after one cycle in SEND.
REQ-025 The minimum transfer SHALL be 4 cycles (IDLE->SEND->WAIT_LOW->ACK->IDLE).

Reset
REQ-026 When reset is sampled high, the following SHALL hold on that edge regardless of state: state=IDLE; gnt, ack, rts, err and v_out =0; xfer_cnt=0; ptr=NREQ-1, so station 0 has first priority.
REQ-027 A reset during SEND or WAIT_LOW SHALL drop rts on the next edge with no ack and no err.

Configuration
REQ-028 With B10_ARB_TIMEOUT_EN defined, a cycle counter SHALL clear on SEND entry and increment each cycle in SEND or WAIT_LOW.
REQ-029 With B10_ARB_TIMEOUT_EN defined, when the counter reaches TIMEOUT the block SHALL, on the next edge, go to IDLE, drop rts and gnt, pulse err for one cycle and set ptr to the aborted winner; it SHALL NOT issue ack or increment xfer_cnt.
REQ-030 Without B10_ARB_TIMEOUT_EN, no counter SHALL exist, err SHALL be tied 0 and the handshake SHALL wait indefinitely.

Structure
REQ-031 Package b10_arb_pkg SHALL hold the state enum, the vote width constant (4) and the xfer_cnt width constant (8).
REQ-032 Round-robin selection SHALL be a combinational sub-module b10_rr_pick (inputs req and ptr; outputs one-hot winner and valid).

Verification
REQ-033 After reset, req=4'b1111 with cts echoing rts after 1 cycle SHALL produce gnt sequence 0001,0010,0100,1000,0001 and xfer_cnt 1..5.
REQ-034 req=4'b0100, vote_in[11:8]=4'hA SHALL give rts high 1 cycle later and v_out=4'hA; cts high 3 cycles then low SHALL give one ack=4'b0100 pulse.
REQ-035 With the macro defined, TIMEOUT=15 and cts held 0, err SHALL pulse after 15 cycles in SEND, rts=0, and xfer_cnt SHALL be unchanged.
REQ-036 Reset asserted while in WAIT_LOW with ack pending SHALL give rts=0, gnt=0 and ack=0 next cycle, then station 0 first on re-arbitration.
REQ-037 Starting from xfer_cnt=255, one completed transfer SHALL give xfer_cnt=0.
